// File: rtl/clock_edge_monitor_module.sv
// clock_edge_monitor_module
//   Watches a slow clock (asynchronous to clk_in). It synchronizes the slow
//   clock and reports each rising and falling edge as a one-cycle strobe. It
//   measures the rise-to-rise period in clk_in cycles and flags the slow clock
//   as lost once TIMEOUT cycles pass without a rising edge.
//
// Ports
//   clk_in        system clock; all state changes on its rising edge
//   reset         asynchronous, active-high reset
//   slow_clk_in   observed slow clock (asynchronous)
//   rise_pulse    one-cycle strobe per detected rising edge
//   fall_pulse    one-cycle strobe per detected falling edge
//   period_out    last measured rise-to-rise period (clk_in cycles)
//   period_valid  one-cycle strobe in the cycle period_out updates
//   clock_lost    level, high while the slow clock is considered stopped
module clock_edge_monitor_module #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 30_000_000,
  localparam int N          = $clog2(longint'(TIMEOUT) + 1)
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         slow_clk_in,
  output logic         rise_pulse,
  output logic         fall_pulse,
  output logic [N-1:0] period_out,
  output logic         period_valid,
  output logic         clock_lost
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEAS = 2'd1;
  localparam logic [1:0] ST_LOST = 2'd2;

  localparam logic [N-1:0] TMO = N'(TIMEOUT);
  localparam logic [N-1:0] ONE = N'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  // Bit k is set once the synchronizer holds k+1 real samples taken after reset.
  logic [SYNC_STAGES-1:0] vld_pipe;
  logic                   prev_q;
  // Rising edges are accepted only after a real low has been seen. Without
  // this, a slow clock that is already high at reset release would look like
  // a 0->1 transition against the cleared chain.
  logic                   armed_q;
  logic [1:0]             state_q;
  logic [N-1:0]           cnt_q;

  logic sync_last;
  logic rise;
  logic fall;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise      = sync_last & ~prev_q & armed_q;
  assign fall      = ~sync_last & prev_q;

  // Synchronizer, edge detection and registered strobes
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      vld_pipe   <= '0;
      prev_q     <= 1'b0;
      armed_q    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
      vld_pipe   <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      prev_q     <= sync_last;
      armed_q    <= armed_q | (vld_pipe[SYNC_STAGES-1] & ~sync_last);
      rise_pulse <= rise;
      fall_pulse <= fall;
    end
  end

  // Period measurement / loss detection. The FSM acts on the combinational
  // rise, so period_valid lines up with rise_pulse. The count then equals the
  // distance between consecutive rise_pulse strobes.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      clock_lost   <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state_q)
        ST_IDLE, ST_MEAS: begin
          if (rise) begin
            // A rise wins over a simultaneous timeout.
            if (state_q == ST_MEAS) begin
              period_out   <= cnt_q;
              period_valid <= 1'b1;
            end
            cnt_q   <= ONE;
            state_q <= ST_MEAS;
          end else if (cnt_q == TMO) begin
            state_q    <= ST_LOST;
            clock_lost <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        ST_LOST: begin
          // The count holds here and period_out keeps its last value.
          if (rise) begin
            clock_lost <= 1'b0;
            cnt_q      <= ONE;
            state_q    <= ST_MEAS;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_edge_monitor_module.sv
module tb_clock_edge_monitor_module;
  localparam int S   = 2;
  localparam int TMO = 100;
  localparam int N   = $clog2(TMO + 1);

  logic         clk_in = 1'b0;
  logic         reset = 1'b0;
  logic         slow_clk_in = 1'b0;
  logic         rise_pulse, fall_pulse, period_valid, clock_lost;
  logic [N-1:0] period_out;

  clock_edge_monitor_module #(.SYNC_STAGES(S), .TIMEOUT(TMO)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .slow_clk_in (slow_clk_in),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .period_out  (period_out),
    .period_valid(period_valid),
    .clock_lost  (clock_lost)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic         r;
    logic         f;
    logic         pv;
    logic [N-1:0] p;
    logic         l;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: event timestamps.
  // hist[k-1] holds the slow clock value sampled at edge k after reset release.
  // A transition needs two real (post-reset) consecutive samples. It shows up
  // S edges after the second sample is taken.
  // A period is the edge distance between rises. The clock counts as lost
  // TIMEOUT edges after the last rise (or after edge 1 when no rise has
  // happened since reset).
  bit   hist[$];
  int   e, anchor, last_p;
  bit   have_prior, lost;

  always @(posedge clk_in) begin
    exp_t x;
    bit r, f, pv, a, b;
    x = '0;
    if (reset) begin
      hist.delete();
      e = 0; anchor = 1; last_p = 0; have_prior = 0; lost = 0;
    end else begin
      e++;
      hist.push_back(slow_clk_in);
      r = 0; f = 0; pv = 0;
      if (e - S - 1 >= 1) begin
        a = hist[e-S-2];
        b = hist[e-S-1];
        r = b & ~a;
        f = a & ~b;
      end
      if (r) begin
        if (have_prior && !lost) begin
          pv = 1;
          last_p = e - anchor;
        end
        have_prior = 1;
        lost = 0;
        anchor = e;
      end else if (!lost && (e - anchor == TMO)) begin
        lost = 1;
      end
      x.r = r; x.f = f; x.pv = pv; x.p = N'(last_p); x.l = lost;
    end
    sb.push_back(x);
  end

  // Monitor: compare every cycle's outputs off the active edge
  always @(negedge clk_in) begin
    exp_t m, act;
    if (sb.size() > 0) begin
      m = sb.pop_front();
      act.r = rise_pulse; act.f = fall_pulse; act.pv = period_valid;
      act.p = period_out; act.l = clock_lost;
      vectors++;
      if (act !== m) begin
        miscompares++;
        $display("FAIL outputs t=%0t got r=%b f=%b pv=%b p=%0d lost=%b expected r=%b f=%b pv=%b p=%0d lost=%b",
                 $time, act.r, act.f, act.pv, act.p, act.l, m.r, m.f, m.pv, m.p, m.l);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic step(input logic v);
    slow_clk_in = v;
    @(negedge clk_in);
    #1;
  endtask

  task automatic run(input logic v, input int n);
    repeat (n) step(v);
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      run(1'b1, hi);
      run(1'b0, lo);
    end
  endtask

  task automatic async_reset_check(input string nm);
    reset = 1'b1;
    #1;
    chk(nm, int'({rise_pulse, fall_pulse, period_valid, clock_lost, period_out}), 0);
  endtask

  initial begin
    int h;
    // Reset with the slow clock toggling
    #1 reset = 1'b1;
    #1;
    chk("reset_state", int'({rise_pulse, fall_pulse, period_valid, clock_lost, period_out}), 0);
    repeat (8) step(1'(~slow_clk_in));
    reset = 1'b0;

    // 20-cycle period
    run(1'b0, 5);
    wave(10, 10, 4);
    chk("period_20", int'(period_out), 20);

    // Stuck high -> lost, recovery
    run(1'b1, 130);
    chk("lost_set", int'(clock_lost), 1);
    run(1'b0, 10);
    wave(10, 10, 3);
    chk("lost_clear", int'(clock_lost), 0);
    chk("period_after_lost", int'(period_out), 20);

    // Rise exactly at cnt == TIMEOUT, then just past it
    wave(50, 50, 3);
    chk("period_tmo", int'(period_out), 100);
    chk("tmo_not_lost", int'(clock_lost), 0);
    wave(51, 50, 2);
    chk("period_hold_lost", int'(period_out), 100);

    // Period 4
    wave(2, 2, 8);
    chk("period_4", int'(period_out), 4);

    // Reset 7 cycles into a 20-cycle period
    wave(10, 10, 2);
    run(1'b1, 7);
    async_reset_check("async_rst_mid");
    run(1'b1, 3);
    run(1'b0, 4);
    reset = 1'b0;
    run(1'b0, 6);
    wave(10, 10, 3);
    chk("period_after_rst", int'(period_out), 20);

    // Slow clock already high at reset release
    run(1'b1, 3);
    async_reset_check("async_rst_high");
    run(1'b1, 4);
    reset = 1'b0;
    run(1'b1, 20);
    wave(10, 10, 2);

    // Random half-periods, occasionally long enough to lose the clock
    repeat (40) begin
      h = ($urandom_range(0, 7) == 0) ? 120 : int'($urandom_range(1, 60));
      run(1'b1, h);
      h = ($urandom_range(0, 7) == 0) ? 120 : int'($urandom_range(1, 60));
      run(1'b0, h);
    end

    run(1'b0, 5);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_edge_monitor_module.md
CLOCK_EDGE_MONITOR_MODULE -- requirements
Module: clock_edge_monitor_module

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for slow_clk_in; legal range 2..4.
REQ-002 Parameter TIMEOUT, default 30_000_000: clk_in cycles without a rising edge before the slow clock is declared lost; legal range 2..2^31-1.
REQ-003 Localparam N = $clog2(TIMEOUT+1): width of the cycle counter and of period_out.
REQ-004 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 slow_clk_in  input  1  divided/slow clock under observation; asynchronous to clk_in.
REQ-007 rise_pulse  output  1  one-cycle strobe per detected rising edge of slow_clk_in.
REQ-008 fall_pulse  output  1  one-cycle strobe per detected falling edge of slow_clk_in.
REQ-009 period_out  output  N  last measured rise-to-rise period, in clk_in cycles.
REQ-010 period_valid  output  1  one-cycle strobe, high in the same cycle period_out updates.
REQ-011 clock_lost  output  1  level; high while the slow clock is considered stopped.

Function
REQ-012 slow_clk_in SHALL pass through a SYNC_STAGES flop chain; a further flop (prev) SHALL hold the previous synchronized value.
REQ-013 Edge detect: rise = sync_last & ~prev; fall = ~sync_last & prev; rise_pulse and fall_pulse SHALL be registered versions of these signals.
REQ-014 Latency: slow_clk_in change set up before clk_in edge 0 SHALL produce its pulse in the cycle following clk_in edge SYNC_STAGES (edge 2 for default); pulse width exactly 1 cycle.
REQ-015 FSM states: IDLE (no rising edge seen since reset), MEASURE, LOST; reset state IDLE.
REQ-016 Counter cnt (N bits) SHALL increment by 1 per cycle in IDLE and MEASURE, saturate at TIMEOUT, and hold in LOST.
REQ-017 IDLE: a detected rise SHALL set cnt<=1 and go to MEASURE, with no period capture.
REQ-018 MEASURE: a detected rise SHALL set period_out<=cnt, pulse period_valid, and set cnt<=1; the result is that period_out equals the cycle distance between consecutive rise_pulse assertions.
REQ-019 IDLE or MEASURE: cnt==TIMEOUT with no rise in the same cycle SHALL go to LOST and set clock_lost<=1 on that edge.
REQ-020 Simultaneous rise and cnt==TIMEOUT: rise SHALL win (MEASURE captures period_out=TIMEOUT; IDLE enters MEASURE); clock_lost SHALL stay 0.
REQ-021 LOST: a detected rise SHALL clear clock_lost, set cnt<=1 and go to MEASURE, with no period capture; period_out SHALL retain its last value throughout LOST.
REQ-022 Falls SHALL affect only fall_pulse; they have no effect on FSM, cnt or period_out.
REQ-023 No combinational path from slow_clk_in to any output.

Reset
REQ-024 reset high SHALL immediately, without a clk_in edge, clear the sync chain, prev, cnt, period_out, rise_pulse, fall_pulse, period_valid and clock_lost to 0 and force IDLE.
REQ-025 Reset asserted mid-measurement SHALL discard the partial count; after release, the first rise SHALL NOT produce period_valid.
REQ-026 A slow_clk_in already high at reset release SHALL NOT generate a rise_pulse until it has gone low and then high again.

Verification (bench: SYNC_STAGES=2, TIMEOUT=100)
REQ-027 Reset pulse with slow_clk_in toggling -> all outputs 0 asynchronously; no pulses while reset is high.
REQ-028 slow_clk_in period 20 cycles (10 high/10 low) -> rise_pulse 3 cycles after the first rise with no period_valid; second rise gives period_valid for 1 cycle with period_out=20; fall_pulse 10 cycles after each rise_pulse.
REQ-029 slow_clk_in stuck high after a rise -> clock_lost=1 exactly 100 cycles after that rise_pulse; next rise clears clock_lost, with no period_valid; the following rise reports its true period.
REQ-030 Rise arriving when cnt==100 -> period_out=100, period_valid=1, clock_lost stays 0.
REQ-031 slow_clk_in toggled every 2 clk_in cycles (period 4) -> rise_pulse and fall_pulse alternate every 2 cycles; period_out=4.
REQ-032 reset asserted 7 cycles into a 20-cycle period -> outputs 0 at once; after release, first rise gives no period_valid and the second gives period_out=20.
